instruction_fetch: RTL and testbench
====================================

# instruction_fetch

RV32I instruction fetch stage sitting directly upstream of the instruction decoder. It owns the program counter and issues word-aligned read requests to instruction memory. It buffers returned instruction words in a small FIFO and presents them, with their PC, to decode over a valid/ready handshake. Control-flow redirects (jal/jalr/taken branch) flush the buffer and discard in-flight responses.

## Interface
- RESET_PC, 32'h0000_0000, PC fetched first after reset; bits [1:0] must be 0
- FIFO_DEPTH, 2, instruction buffer entries; power of 2, ≥2; also caps outstanding requests

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  word address of request, bits [1:0] always 0
- imem_rsp_valid  in  1  read data valid; in request order, always accepted, ≥1 cycle after accept
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  one-cycle redirect strobe from execute
- redirect_pc  in  32  redirect target
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode consumes
- out_instruction  out  32  instruction word
- out_pc  out  32  address of out_instruction
- misaligned  out  1  misaligned redirect trap flag

## Operation
- State: fetch_pc (32), outstanding (live requests), discard (stale requests to drop), FIFO of {pc, instruction}, halted (macro only).
- Request: imem_req_valid = !redirect_valid && !halted && (outstanding + discard + fifo_count < FIFO_DEPTH); imem_req_addr = fetch_pc. On accept: fetch_pc += 4 (wraps mod 2^32), outstanding++.
- Response: if discard > 0, drop, discard--; else push {pc tag, data} into FIFO, outstanding--. The pc tag comes from a per-request queue or pc counter.
- Credit rule guarantees FIFO never overflows; responses are never backpressured.
- Output: head of FIFO; pop on out_valid && out_ready.
- Redirect (redirect_valid=1): FIFO cleared; fetch_pc ← redirect_pc; discard ← outstanding + discard − (imem_rsp_valid ? 1 : 0); outstanding ← 0. A response in the same cycle is stale and dropped. A pop in the same cycle completes normally. Redirect overrides all other updates.
- Back-to-back redirects: the last one wins; discard accumulates correctly.

## Timing
- Reset values: fetch_pc=RESET_PC, FIFO empty, outstanding=0, discard=0, halted=0, misaligned=0, out_valid=0, out_instruction=0, out_pc=0.
- imem_req_valid may assert the first cycle rst_n is high.
- Response in cycle N (FIFO empty) → out_valid=1 in cycle N+1. FIFO is registered, with no combinational rsp→out path.
- Redirect in cycle N → out_valid=0 in N+1. First request with addr=redirect_pc is presented in N+1.
- While imem_req_valid && !imem_req_ready, imem_req_addr is held stable (unless redirect).
- out_instruction/out_pc are held stable while out_valid && !out_ready.
- Full sustained throughput is 1 instruction/cycle for 1-cycle memory latency.
- rst_n asserted mid-operation: all state returns to reset values immediately. Memory must not return responses for pre-reset requests.

## Configuration
- IFETCH_MISALIGN_TRAP_EN defined:
  - A redirect with redirect_pc[1:0]≠0 sets halted=1 and misaligned=1 from the next cycle.
  - While halted, no requests are issued and out_valid=0.
  - Stale responses are still discarded.
  - The next redirect with an aligned target clears both flags and resumes fetching at that target.
- Undefined: fetch_pc ← {redirect_pc[31:2], 2'b00}; misaligned tied 0; no halted state.

## Test plan
- RESET_PC=0x100, memory always ready, 1-cycle latency, out_ready=1 → requests 0x100, 0x104, 0x108…; out_pc/out_instruction match in order, 1 instruction/cycle after fill.
- out_ready=0 for 10 cycles → at most FIFO_DEPTH (2) accepted requests, then imem_req_valid=0. Release → all instructions delivered in order, none lost or duplicated.
- 3-cycle memory latency, 2 requests in flight, redirect to 0x200 → both stale responses dropped; next out_pc=0x200 with correct data.
- Redirect in the same cycle as imem_rsp_valid and an out handshake → popped instruction delivered; response dropped; next out_pc=redirect target.
- imem_req_ready toggling 1/0 pseudo-randomly → imem_req_addr stable while stalled, strictly sequential +4 across accepts.
- Macro on: redirect 0x202 → misaligned=1, no requests; then redirect 0x300 → misaligned=0, fetch 0x300. Macro off: redirect 0x202 → fetch 0x200, misaligned=0.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Bus bundle for the instruction fetch stage: imem request/response, execute redirect and decode-facing output.
// master is the fetch stage itself; slave is the surrounding memory/pipeline.
interface instruction_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;
  logic        misaligned;

  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_instruction, out_pc, misaligned,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_instruction, out_pc, misaligned,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/instruction_fetch.sv
// RV32I fetch stage: owns the PC, issues credit-limited word reads and buffers {pc, instruction} for decode.
// Optional feature macro IFETCH_MISALIGN_TRAP_EN: a misaligned redirect halts fetch and raises misaligned.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  instruction_fetch_if.master bus
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SUM_W = CNT_W + 2;

  logic [31:0]      fetch_pc_r;
  logic [31:0]      rsp_pc_r;  // pc of the oldest live outstanding request
  logic [CNT_W-1:0] outstanding_r;
  logic [CNT_W-1:0] discard_r;
  logic [CNT_W-1:0] count_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [31:0]      pc_mem_r    [FIFO_DEPTH];
  logic [31:0]      instr_mem_r [FIFO_DEPTH];

  logic             halted_s;
  logic             out_valid_s;
  logic             pop_s;
  logic             req_valid_s;
  logic             accept_s;
  logic             rsp_live_s;
  logic             rsp_drop_s;
  logic             push_s;
  logic [SUM_W-1:0] in_use_s;
  logic [31:0]      target_s;
  logic [CNT_W-1:0] outstanding_nx_s;
  logic [CNT_W-1:0] discard_nx_s;
  logic [CNT_W-1:0] count_nx_s;

  // Handshake qualification and request credit; a same-cycle pop frees its slot for a new request.
  always_comb begin
    out_valid_s = (count_r != '0) && !halted_s;
    pop_s       = out_valid_s && bus.out_ready;
    in_use_s    = SUM_W'(outstanding_r) + SUM_W'(discard_r) + SUM_W'(count_r) - SUM_W'(pop_s);
    req_valid_s = !bus.redirect_valid && !halted_s && (in_use_s < SUM_W'(FIFO_DEPTH));
    accept_s    = req_valid_s && bus.imem_req_ready;
    rsp_drop_s  = bus.imem_rsp_valid && (discard_r != '0);
    rsp_live_s  = bus.imem_rsp_valid && (discard_r == '0);
    push_s      = rsp_live_s && !bus.redirect_valid;
    target_s    = {bus.redirect_pc[31:2], 2'b00};
  end

  // Next values of the in-flight and buffer occupancy counters; a redirect turns live requests stale.
  always_comb begin
    outstanding_nx_s = outstanding_r;
    discard_nx_s     = discard_r;
    count_nx_s       = count_r;
    if (bus.redirect_valid) begin
      outstanding_nx_s = '0;
      discard_nx_s     = outstanding_r + discard_r - CNT_W'(bus.imem_rsp_valid);
      count_nx_s       = '0;
    end else begin
      outstanding_nx_s = outstanding_r + CNT_W'(accept_s) - CNT_W'(rsp_live_s);
      if (rsp_drop_s) begin
        discard_nx_s = discard_r - CNT_W'(1'b1);
      end else begin
        discard_nx_s = discard_r;
      end
      count_nx_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_r <= '0;
      discard_r     <= '0;
      count_r       <= '0;
    end else begin
      outstanding_r <= outstanding_nx_s;
      discard_r     <= discard_nx_s;
      count_r       <= count_nx_s;
    end
  end

  // Program counter and response pc tag; responses arrive in order so the tag simply steps by 4.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
      rsp_pc_r   <= RESET_PC;
    end else if (bus.redirect_valid) begin
      fetch_pc_r <= target_s;
      rsp_pc_r   <= target_s;
    end else begin
      if (accept_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end
      if (push_s) begin
        rsp_pc_r <= rsp_pc_r + 32'd4;
      end
    end
  end

  // Instruction buffer storage and pointers; a redirect empties it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_r[i]    <= '0;
        instr_mem_r[i] <= '0;
      end
    end else if (bus.redirect_valid) begin
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
    end else begin
      if (push_s) begin
        pc_mem_r[wr_ptr_r]    <= rsp_pc_r;
        instr_mem_r[wr_ptr_r] <= bus.imem_rsp_data;
        wr_ptr_r              <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
    end
  end

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic misaligned_r;  // doubles as the halted state

  // Trap flag: set by a misaligned redirect, cleared by the next aligned one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned_r <= 1'b0;
    end else if (bus.redirect_valid) begin
      misaligned_r <= (bus.redirect_pc[1:0] != 2'b00);
    end else begin
      misaligned_r <= misaligned_r;
    end
  end

  assign halted_s       = misaligned_r;
  assign bus.misaligned = misaligned_r;
`else
  assign halted_s       = 1'b0;
  assign bus.misaligned = 1'b0;
`endif

  assign bus.imem_req_valid  = req_valid_s;
  assign bus.imem_req_addr   = fetch_pc_r;
  assign bus.out_valid       = out_valid_s;
  assign bus.out_instruction = instr_mem_r[rd_ptr_r];
  assign bus.out_pc          = pc_mem_r[rd_ptr_r];

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: behavioural in-order memory, scoreboard of expected {pc, instr},
// a table of redirect vectors and hand-written sequences for the multi-cycle corner cases.
module tb_instruction_fetch;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef struct {
    logic [31:0] target;
    logic [31:0] exp_addr;
    logic        exp_mis;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  instruction_fetch_if bus();

  instruction_fetch #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  entry_t      sb_q[$];
  logic [31:0] mem_addr_q[$];
  int          mem_due_q[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc, lat, ready_pct, oready_pct, delivered, accepted, d0, a0;
  logic [31:0] exp_addr, redir_target, held_addr, first_exp, vec_addr;
  logic        halted_m, redir_req, prev_redir, stall_hold, out_hold, chk_first, vec_chk, vec_mis, found;
  entry_t      held_out;
  vec_t        vecs[3];

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic reset_checks();
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("rst_req_addr", bus.imem_req_addr, 32'h0000_0100);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_pc", bus.out_pc, 32'd0);
    check("rst_out_instruction", bus.out_instruction, 32'd0);
    check("rst_misaligned", 32'(bus.misaligned), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'd0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'd0;
    bus.out_ready      = 1'b0;
    #1;
    check("async_reset_out_valid", 32'(bus.out_valid), 32'd0);
    sb_q.delete();
    mem_addr_q.delete();
    mem_due_q.delete();
    exp_addr = 32'h0000_0100;
    halted_m = 1'b0; redir_req = 1'b0; prev_redir = 1'b0; stall_hold = 1'b0;
    out_hold = 1'b0; chk_first = 1'b0; vec_chk = 1'b0;
    cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    reset_checks();
  endtask

  // One clock cycle: drive inputs at negedge, sample/score 1 time unit later, then wait for the edge.
  task automatic step();
    entry_t e;
    @(negedge clk);
    bus.out_ready      = ($urandom_range(99) < oready_pct);
    bus.imem_req_ready = ($urandom_range(99) < ready_pct);
    bus.redirect_valid = redir_req;
    bus.redirect_pc    = redir_target;
    if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = data_of(mem_addr_q[0]);
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
    check("misaligned", 32'(bus.misaligned), 32'(halted_m));
    if (prev_redir) check("out_valid_after_redirect", 32'(bus.out_valid), 32'd0);
    if (redir_req) check("req_during_redirect", 32'(bus.imem_req_valid), 32'd0);
    if (halted_m) begin
      check("halted_req_valid", 32'(bus.imem_req_valid), 32'd0);
      check("halted_out_valid", 32'(bus.out_valid), 32'd0);
    end
    if (stall_hold && !redir_req && bus.imem_req_valid)
      check("req_addr_stable", bus.imem_req_addr, held_addr);
    if (out_hold) begin
      check("out_hold_valid", 32'(bus.out_valid), 32'd1);
      check("out_hold_pc", bus.out_pc, held_out.pc);
      check("out_hold_instruction", bus.out_instruction, held_out.instr);
    end
    if (vec_chk) begin
      if (!vec_mis) begin
        check("vec_req_valid", 32'(bus.imem_req_valid), 32'd1);
        check("vec_req_addr", bus.imem_req_addr, vec_addr);
      end
      vec_chk = 1'b0;
    end
    if (bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_output: got pc %h, scoreboard empty", bus.out_pc);
      end else begin
        e = sb_q.pop_front();
        check("out_pc", bus.out_pc, e.pc);
        check("out_instruction", bus.out_instruction, e.instr);
      end
      if (chk_first) begin
        check("first_pc_after_redirect", bus.out_pc, first_exp);
        chk_first = 1'b0;
      end
      delivered++;
    end
    if (bus.imem_req_valid && bus.imem_req_ready) begin
      check("req_addr", bus.imem_req_addr, exp_addr);
      mem_addr_q.push_back(bus.imem_req_addr);
      mem_due_q.push_back(cyc + lat);
      e.pc = exp_addr;
      e.instr = data_of(exp_addr);
      sb_q.push_back(e);
      exp_addr = exp_addr + 32'd4;
      accepted++;
    end
    if (bus.imem_rsp_valid) begin
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end
    if (redir_req) begin
      sb_q.delete();
      exp_addr = {redir_target[31:2], 2'b00};
`ifdef IFETCH_MISALIGN_TRAP_EN
      halted_m = (redir_target[1:0] != 2'b00);
`endif
      chk_first = !halted_m;
      first_exp = exp_addr;
    end
    stall_hold  = bus.imem_req_valid && !bus.imem_req_ready && !redir_req;
    held_addr   = bus.imem_req_addr;
    out_hold    = bus.out_valid && !bus.out_ready && !redir_req;
    held_out.pc = bus.out_pc;
    held_out.instr = bus.out_instruction;
    prev_redir  = redir_req;
    redir_req   = 1'b0;
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    delivered = 0; accepted = 0; redir_target = 32'd0;
`ifdef IFETCH_MISALIGN_TRAP_EN
    vecs[0] = '{target: 32'h0000_0202, exp_addr: 32'h0000_0000, exp_mis: 1'b1};
    vecs[1] = '{target: 32'h0000_0300, exp_addr: 32'h0000_0300, exp_mis: 1'b0};
    vecs[2] = '{target: 32'h0000_01F0, exp_addr: 32'h0000_01F0, exp_mis: 1'b0};
`else
    vecs[0] = '{target: 32'h0000_0202, exp_addr: 32'h0000_0200, exp_mis: 1'b0};
    vecs[1] = '{target: 32'h0000_0303, exp_addr: 32'h0000_0300, exp_mis: 1'b0};
    vecs[2] = '{target: 32'h0000_01F0, exp_addr: 32'h0000_01F0, exp_mis: 1'b0};
`endif
    do_reset();

    // Streaming from RESET_PC at one instruction per cycle once filled.
    lat = 1; ready_pct = 100; oready_pct = 100;
    repeat (4) step();
    d0 = delivered;
    repeat (20) step();
    check("throughput", 32'(delivered - d0), 32'd20);

    // Decode stalls: request credit caps what is accepted.
    oready_pct = 0;
    a0 = accepted;
    repeat (10) step();
    check("accept_cap", 32'((accepted - a0) <= 2), 32'd1);
    @(negedge clk);
    #1;
    check("req_valid_blocked", 32'(bus.imem_req_valid), 32'd0);
    check("buffered_entries", 32'(sb_q.size()), 32'd2);
    oready_pct = 100;
    repeat (8) step();

    // Random memory and decode backpressure.
    ready_pct = 50; oready_pct = 70;
    repeat (60) step();

    // Redirect with two requests in flight at 3-cycle latency.
    lat = 3; ready_pct = 100; oready_pct = 100;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (mem_addr_q.size() == 2) begin
        found = 1'b1;
        redir_req = 1'b1;
        redir_target = 32'h0000_0200;
      end
      step();
    end
    check("two_in_flight_found", 32'(found), 32'd1);
    repeat (15) step();
    check("redirect_target_delivered", 32'(chk_first), 32'd0);

    // Redirect coinciding with a response and an output handshake.
    lat = 1;
    repeat (5) step();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      #1;
      if (bus.out_valid && mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
        found = 1'b1;
        redir_req = 1'b1;
        redir_target = 32'h0000_0400;
        d0 = delivered;
        step();
        check("pop_with_redirect", 32'(delivered - d0), 32'd1);
      end else begin
        step();
      end
    end
    check("coincident_case_found", 32'(found), 32'd1);
    repeat (10) step();
    check("coincident_target_delivered", 32'(chk_first), 32'd0);

    // Redirect target alignment table.
    for (int v = 0; v < 3; v++) begin
      repeat (5) step();
      redir_req = 1'b1;
      redir_target = vecs[v].target;
      step();
      vec_chk = 1'b1;
      vec_addr = vecs[v].exp_addr;
      vec_mis = vecs[v].exp_mis;
      a0 = accepted;
      repeat (8) step();
      check("vec_misaligned_model", 32'(halted_m), 32'(vecs[v].exp_mis));
      if (vecs[v].exp_mis) begin
        check("vec_no_requests", 32'(accepted - a0), 32'd0);
      end else begin
        check("vec_target_delivered", 32'(chk_first), 32'd0);
      end
    end

    // Reset in the middle of streaming.
    repeat (5) step();
    do_reset();
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
